// File: rtl/spi_target_byte_if.sv
// Bundle of SPI pins, RX/TX byte streams and status flags for spi_target_byte.
// The slave modport is the target's view; master is the controller/host side.
interface spi_target_byte_if;
  logic       spi_sck_i;
  logic       spi_cs_ni;
  logic       spi_copi_i;
  logic       spi_cipo_o;
  logic       spi_cipo_en_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       overflow_o;
  logic       underrun_o;
  logic       err_clear_i;
  logic       busy_o;

  modport slave (
    input  spi_sck_i, spi_cs_ni, spi_copi_i, rx_ready_i, tx_data_i, tx_valid_i, err_clear_i,
    output spi_cipo_o, spi_cipo_en_o, rx_data_o, rx_valid_o, tx_ready_o, overflow_o,
           underrun_o, busy_o
  );

  modport master (
    output spi_sck_i, spi_cs_ni, spi_copi_i, rx_ready_i, tx_data_i, tx_valid_i, err_clear_i,
    input  spi_cipo_o, spi_cipo_en_o, rx_data_o, rx_valid_o, tx_ready_o, overflow_o,
           underrun_o, busy_o
  );
endinterface

// File: rtl/spi_target_byte.sv
// SPI mode-0 target: oversamples SCK/CS/COPI in clk_sys, deserialises COPI into an RX FIFO
// and serialises host-supplied bytes (or TxIdle) onto CIPO, MSB first.
module spi_target_byte #(
  parameter int unsigned RxDepth = 4,
  parameter logic [7:0]  TxIdle  = 8'hFF
) (
  input  logic           clk_sys_i,
  input  logic           rst_sys_i,
  spi_target_byte_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(RxDepth);
  localparam int unsigned CountW = PtrW + 1;
  localparam logic [0:0]  StIdle   = 1'b0;
  localparam logic [0:0]  StActive = 1'b1;

  logic sck_meta, sck_sync, sck_prev;
  logic cs_meta, cs_sync, cs_prev;
  logic copi_meta, copi_sync;

  // CS resets to the deasserted level so a held-low CS after reset is seen as a fresh fall.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      {sck_meta, sck_sync, sck_prev} <= 3'b000;
      {cs_meta, cs_sync, cs_prev}    <= 3'b111;
      {copi_meta, copi_sync}         <= 2'b00;
    end else begin
      sck_meta  <= bus.spi_sck_i;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
      cs_meta   <= bus.spi_cs_ni;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      copi_meta <= bus.spi_copi_i;
      copi_sync <= copi_meta;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign cs_fall  = ~cs_sync & cs_prev;
  assign cs_rise  = cs_sync & ~cs_prev;

  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, hold;
  logic       hold_full, byte_done, cipo_en_q, overflow_q, underrun_q;

  logic       do_load, do_rx, push, tx_accept;
  logic [7:0] push_data, load_byte;

  // A CS rise masks any SCK edge detected in the same cycle.
  always_comb begin
    do_load = 1'b0;
    do_rx   = 1'b0;
    if (state == StIdle) begin
      do_load = cs_fall;
    end else if (!cs_rise) begin
      do_rx   = sck_rise;
      do_load = sck_fall & byte_done;
    end
  end

  assign push      = do_rx & (bit_cnt == 3'd7);
  assign push_data = {rx_shift, copi_sync};
  assign load_byte = hold_full ? hold : TxIdle;
  assign tx_accept = bus.tx_valid_i & ~hold_full;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state     <= StIdle;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'd0;
      byte_done <= 1'b0;
      cipo_en_q <= 1'b0;
    end else if (state == StIdle) begin
      if (cs_fall) begin
        state     <= StActive;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        tx_shift  <= load_byte;
        cipo_en_q <= 1'b1;
      end
    end else if (cs_rise) begin
      state     <= StIdle;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      byte_done <= 1'b0;
      cipo_en_q <= 1'b0;
    end else if (sck_rise) begin
      rx_shift  <= push_data[6:0];
      bit_cnt   <= bit_cnt + 3'd1;
      byte_done <= (bit_cnt == 3'd7);
    end else if (sck_fall) begin
      byte_done <= 1'b0;
      tx_shift  <= byte_done ? load_byte : {tx_shift[6:0], 1'b0};
    end
  end

  // A same-cycle write and load: the load sees the pre-write contents, the write lands after.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else begin
      if (tx_accept) hold <= bus.tx_data_i;
      hold_full <= tx_accept | (hold_full & ~do_load);
    end
  end

  logic [7:0]        mem [RxDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [CountW-1:0] count, count_after_pop, count_next;
  logic              fifo_pop, fifo_full, push_ok, ovf_set, rx_valid_q;
  logic [7:0]        rx_data_q;

  always_comb begin
    fifo_pop        = rx_valid_q & bus.rx_ready_i;
    fifo_full       = (count == CountW'(RxDepth));
    push_ok         = push & (~fifo_full | fifo_pop);
    ovf_set         = push & fifo_full & ~fifo_pop;
    count_after_pop = count - CountW'(fifo_pop);
    count_next      = count_after_pop + CountW'(push_ok);
    rd_next         = rd_ptr + PtrW'(fifo_pop);
  end

  always_ff @(posedge clk_sys_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // rx_data_o is registered: it tracks whatever will be at the head after this cycle's push/pop.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      rd_ptr     <= rd_next;
      count      <= count_next;
      rx_valid_q <= (count_next != '0);
      if (push_ok && count_after_pop == '0) rx_data_q <= push_data;
      else if (count_next != '0)            rx_data_q <= mem[rd_next];
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i || bus.err_clear_i) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (ovf_set) overflow_q <= 1'b1;
      if (do_load && !hold_full) underrun_q <= 1'b1;
    end
  end

  assign bus.spi_cipo_o    = cipo_en_q ? tx_shift[7] : 1'b1;
  assign bus.spi_cipo_en_o = cipo_en_q;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.tx_ready_o    = ~hold_full;
  assign bus.overflow_o    = overflow_q;
  assign bus.underrun_o    = underrun_q;
  assign bus.busy_o        = (state == StActive);
endmodule
